// File: rtl/sigma_delta_dac2.sv
// Second-order (or first-order) 1-bit sigma-delta DAC: unsigned 20-bit PCM in,
// pulse-density bitstream out whose ones density equals pcm_in / 2^20.
module sigma_delta_dac2 #(
  parameter int IW    = 24,
  parameter int ORDER = 2
) (
  input  logic        clk_dac,
  input  logic        rst,
  input  logic        clk_ena,
  input  logic [19:0] pcm_in,
  output logic        dac_out
);

  localparam int XW = IW + 2;
  typedef logic signed [XW-1:0] wide_t;

  localparam wide_t HALF    = wide_t'(524288);
  localparam wide_t SAT_MAX = $signed({3'b000, {(IW-1){1'b1}}});
  localparam wide_t SAT_MIN = $signed({3'b111, {(IW-1){1'b0}}});

  // Clamp a widened sum back into the IW-bit integrator range; never wrap.
  function automatic logic signed [IW-1:0] sat(input wide_t x);
    if (x > SAT_MAX)      sat = $signed(SAT_MAX[IW-1:0]);
    else if (x < SAT_MIN) sat = $signed(SAT_MIN[IW-1:0]);
    else                  sat = $signed(x[IW-1:0]);
  endfunction

  logic        [19:0]   r_sample;
  logic signed [IW-1:0] r_int1;
  logic signed [IW-1:0] r_int2;
  logic                 r_dac;

  wide_t                w_xs;
  wide_t                w_fb;
  wide_t                w_sum1;
  logic signed [IW-1:0] w_int1n;
  logic signed [IW-1:0] w_int2n;
  logic                 w_dac_n;

  assign w_xs    = $signed({{(XW-20){1'b0}}, r_sample}) - HALF;
  assign w_fb    = r_dac ? HALF : -HALF;
  assign w_sum1  = $signed({{2{r_int1[IW-1]}}, r_int1}) + w_xs - w_fb;
  assign w_int1n = sat(w_sum1);

  generate
    if (ORDER == 1) begin : g_first_order
      assign w_int2n = w_int1n;
    end else begin : g_second_order
      wide_t w_sum2;
      // Second integrator is fed the freshly updated first integrator.
      assign w_sum2  = $signed({{2{r_int2[IW-1]}}, r_int2})
                     + $signed({{2{w_int1n[IW-1]}}, w_int1n}) - w_fb;
      assign w_int2n = sat(w_sum2);
    end
  endgenerate

  assign w_dac_n = ~w_int2n[IW-1];

  always_ff @(posedge clk_dac or posedge rst) begin
    if (rst) begin
      r_sample <= 20'h80000;
      r_int1   <= '0;
      r_int2   <= '0;
      r_dac    <= 1'b0;
    end else if (clk_ena) begin
      r_sample <= pcm_in;
      r_int1   <= w_int1n;
      r_int2   <= w_int2n;
      r_dac    <= w_dac_n;
    end
  end

  assign dac_out = r_dac;

endmodule

// File: tb/tb_sigma_delta_dac2.sv
// Bench for sigma_delta_dac2: table-driven density vectors, hand-written corner
// sequences, and randomized streams checked against an arithmetic reference model.
module tb_sigma_delta_dac2;

  logic        clk_dac = 1'b0;
  logic        rst;
  logic        clk_ena;
  logic [19:0] pcm_in;
  logic        dac_out;

  sigma_delta_dac2 #(.IW(24), .ORDER(2)) dut (
    .clk_dac (clk_dac),
    .rst     (rst),
    .clk_ena (clk_ena),
    .pcm_in  (pcm_in),
    .dac_out (dac_out)
  );

  // Clock / reset
  always #5 clk_dac = ~clk_dac;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: integrators as plain integers with an explicit clamp.
  localparam longint HALF   = 64'sd524288;
  localparam longint LIM_HI = (64'sd1 <<< 23) - 1;
  localparam longint LIM_LO = -(64'sd1 <<< 23);

  longint     m_int1;
  longint     m_int2;
  longint     m_sample;
  logic       m_out;
  logic [0:0] exp_q[$];

  function automatic longint clamp(input longint v);
    if (v > LIM_HI) return LIM_HI;
    if (v < LIM_LO) return LIM_LO;
    return v;
  endfunction

  task automatic model_reset();
    m_sample = HALF;
    m_int1   = 0;
    m_int2   = 0;
    m_out    = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [19:0] pcm);
    longint xs;
    longint fb;
    longint n1;
    longint n2;
    xs       = m_sample - HALF;
    fb       = m_out ? HALF : -HALF;
    n1       = clamp(m_int1 + xs - fb);
    n2       = clamp(m_int2 + n1 - fb);
    m_int1   = n1;
    m_int2   = n2;
    m_out    = (n2 >= 0);
    m_sample = longint'(pcm);
    exp_q.push_back(m_out);
  endtask

  // Scoreboard checks
  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: dac_out=%0b expected=%0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Drivers: every call starts and ends on a falling edge.
  task automatic do_reset();
    rst     = 1'b1;
    clk_ena = 1'b0;
    repeat (3) @(negedge clk_dac);
    check_bit("reset_state", dac_out, 1'b0);
    rst = 1'b0;
    model_reset();
    @(negedge clk_dac);
  endtask

  task automatic en_step(input logic [19:0] pcm, input int idle, output logic got);
    logic [0:0] e;
    pcm_in  = pcm;
    clk_ena = 1'b1;
    @(negedge clk_dac);
    clk_ena = 1'b0;
    model_step(pcm);
    e   = exp_q.pop_front();
    got = dac_out;
    check_bit("stream", got, e[0]);
    repeat (idle) @(negedge clk_dac);
  endtask

  typedef struct {
    logic [19:0] pcm;
    int          idle;
    int          warmup;
    int          n;
    int          exp_ones;
    int          tol;
  } dens_vec_t;

  initial begin
    dens_vec_t  dvec[3];
    logic       got;
    logic [4:0] first5;
    logic       held;
    int         ones;
    logic [19:0] rp;
    longint     exp_ones;

    dvec[0] = '{pcm: 20'h80000, idle: 3, warmup: 0,  n: 4096, exp_ones: 2048, tol: 4};
    dvec[1] = '{pcm: 20'h40000, idle: 0, warmup: 16, n: 4096, exp_ones: 1024, tol: 4};
    dvec[2] = '{pcm: 20'hC0000, idle: 0, warmup: 16, n: 4096, exp_ones: 3072, tol: 4};

    rst     = 1'b1;
    clk_ena = 1'b0;
    pcm_in  = 20'h80000;
    @(negedge clk_dac);

    // First five outputs after reset at midscale, enable every 4th cycle.
    do_reset();
    first5 = 5'b11010;
    for (int k = 0; k < 5; k++) begin
      en_step(20'h80000, 3, got);
      check_bit("first5", got, first5[4-k]);
    end

    // Density table
    for (int v = 0; v < 3; v++) begin
      do_reset();
      for (int k = 0; k < dvec[v].warmup; k++) en_step(dvec[v].pcm, dvec[v].idle, got);
      ones = 0;
      for (int k = 0; k < dvec[v].n; k++) begin
        en_step(dvec[v].pcm, dvec[v].idle, got);
        ones += int'(got);
      end
      check_range($sformatf("density_%05h", dvec[v].pcm), ones,
                  dvec[v].exp_ones - dvec[v].tol, dvec[v].exp_ones + dvec[v].tol);
    end

    // Latency: step presented on edge 6 still runs on the old sample.
    do_reset();
    for (int k = 0; k < 5; k++) en_step(20'h80000, 1, got);
    en_step(20'hC0000, 1, got);
    check_bit("latency_old", got, 1'b0);
    en_step(20'hC0000, 1, got);
    check_bit("latency_new", got, 1'b1);

    // Enable gating: 100 disabled cycles with a moving input, then resume.
    for (int k = 0; k < 20; k++) en_step(20'hC0000, 0, got);
    held = dac_out;
    for (int k = 0; k < 100; k++) begin
      pcm_in = 20'($urandom_range(0, 20'hFFFFF));
      @(negedge clk_dac);
      check_bit("gated_hold", dac_out, held);
    end
    for (int k = 0; k < 50; k++) en_step(20'hC0000, 0, got);

    // Asynchronous reset between edges while streaming.
    for (int k = 0; k < 37; k++) en_step(20'hC0000, 0, got);
    @(posedge clk_dac);
    #3 rst = 1'b1;
    #1 check_bit("async_reset", dac_out, 1'b0);
    @(negedge clk_dac);
    rst = 1'b0;
    model_reset();
    @(negedge clk_dac);
    for (int k = 0; k < 64; k++) en_step(20'hC0000, 0, got);

    // Saturation: long run at zero, then recovery at midscale.
    do_reset();
    ones = 0;
    for (int k = 0; k < 10000; k++) begin
      en_step(20'h00000, 0, got);
      if (k >= 10) ones += int'(got);
    end
    check_range("sat_zero_ones", ones, 0, 0);
    ones = 0;
    for (int k = 0; k < 6000; k++) begin
      en_step(20'h80000, 0, got);
      if (k >= 2000) ones += int'(got);
    end
    check_range("sat_recovery", ones, 1960, 2040);

    // Random constant samples inside the guaranteed band.
    for (int r = 0; r < 4; r++) begin
      rp = 20'($urandom_range(20'h40000, 20'hC0000));
      do_reset();
      for (int k = 0; k < 16; k++) en_step(rp, 0, got);
      ones = 0;
      for (int k = 0; k < 2048; k++) begin
        en_step(rp, 0, got);
        ones += int'(got);
      end
      exp_ones = (longint'(2048) * longint'(rp) + 64'sd524288) >>> 20;
      check_range($sformatf("density_rand_%05h", rp), ones,
                  int'(exp_ones) - 4, int'(exp_ones) + 4);
    end

    // Random full-range stream with aperiodic enables.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      en_step(20'($urandom_range(0, 20'hFFFFF)), $urandom_range(0, 3), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
